// File: rtl/m31_round_ctrl_if.sv
// m31_round_ctrl_if: handshake and datapath bus for the M31 Poseidon2 round sequencer
// Parameters: WIDTH state lanes (31-bit each), RW pass-index width ($clog2 of pass count)
// Signals:
//   in_valid/in_ready/in_state      input state handshake (state offered to the controller)
//   out_valid/out_ready/out_state   result handshake
//   dp_valid_o/dp_kind_o/dp_round_o/dp_state_o   issue towards the shared round datapath
//   dp_state_i                      datapath result
//   busy_o                          controller not idle
// Modports: slave = controller side, master = producer/consumer/datapath side
interface m31_round_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int RW    = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0][30:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0][30:0] out_state;
    logic                   dp_valid_o;
    logic [1:0]             dp_kind_o;
    logic [RW-1:0]          dp_round_o;
    logic [WIDTH-1:0][30:0] dp_state_o;
    logic [WIDTH-1:0][30:0] dp_state_i;
    logic                   busy_o;
    modport slave (
        input  in_valid, in_state, out_ready, dp_state_i,
        output in_ready, out_valid, out_state, dp_valid_o, dp_kind_o, dp_round_o, dp_state_o, busy_o
    );
    modport master (
        output in_valid, in_state, out_ready, dp_state_i,
        input  in_ready, out_valid, out_state, dp_valid_o, dp_kind_o, dp_round_o, dp_state_o, busy_o
    );
endinterface

// File: rtl/m31_round_ctrl.sv
// m31_round_ctrl: iterative M31 Poseidon2 permutation sequencer driving one shared round datapath
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   abort_i   abandon the current permutation (only when M31_RC_ABORT_EN is defined)
//   bus       m31_round_ctrl_if.slave: in/out valid-ready handshakes, datapath issue/return, busy_o
// Parameters: WIDTH lanes, DP_LAT datapath latency (>=1), R_F full rounds (even), R_P partial rounds
// Optional feature: define M31_RC_ABORT_EN to add the abort_i port.
module m31_round_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DP_LAT = 1,
    parameter int R_F    = 8,
    parameter int R_P    = 14
) (
    input logic clk,
    input logic rst_n,
`ifdef M31_RC_ABORT_EN
    input logic abort_i,
`endif
    m31_round_ctrl_if.slave bus
);
    localparam int T  = 1 + R_F + R_P;
    localparam int RW = $clog2(T);
    localparam int CW = $clog2(DP_LAT + 1);
    localparam logic [RW-1:0] HALF = RW'(R_F / 2);
    localparam logic [RW-1:0] PEND = RW'(R_F / 2 + R_P);
    localparam logic [RW-1:0] LAST = RW'(T - 1);
    localparam logic [CW-1:0] CLD  = CW'(DP_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0][30:0] st_q;
    logic [RW-1:0]          pass;
    logic [CW-1:0]          cnt;
    logic [1:0]             kind;
    logic                   in_ready, out_valid, dp_valid, busy;
    logic                   clr;

    // pass 0 is the initial linear layer; full rounds bracket the partial rounds
    function automatic logic [1:0] kind_of(input logic [RW-1:0] p);
        return p == '0 ? 2'b00 : p <= HALF ? 2'b01 : p <= PEND ? 2'b10 : 2'b01;
    endfunction

`ifdef M31_RC_ABORT_EN
    assign clr = abort_i && state != IDLE;
`else
    assign clr = 1'b0;
`endif

    // abort behaves exactly like reset; a coincident out handshake is consumed either way
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= IDLE;
            st_q      <= '0;
            pass      <= '0;
            cnt       <= '0;
            kind      <= 2'b00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dp_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    st_q     <= bus.in_state;
                    pass     <= '0;
                    kind     <= kind_of('0);
                    state    <= ISSUE;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    dp_valid <= 1'b1;
                end
                ISSUE: begin
                    cnt      <= CLD;
                    dp_valid <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    st_q <= bus.dp_state_i;
                    if (pass == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        pass     <= pass + 1'b1;
                        kind     <= kind_of(pass + 1'b1);
                        state    <= ISSUE;
                        dp_valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_state  = st_q;
    assign bus.dp_valid_o = dp_valid;
    assign bus.dp_kind_o  = kind;
    assign bus.dp_round_o = pass;
    assign bus.dp_state_o = st_q;
    assign bus.busy_o     = busy;
endmodule

// File: tb/tb_m31_round_ctrl.sv
// tb_m31_round_ctrl: self-checking bench for m31_round_ctrl with stub datapaths (DP_LAT 1 and 3)
// Stub datapath: every lane +1 mod p, lane 0 additionally + pass index.
// Honours M31_RC_ABORT_EN when defined.
module tb_m31_round_ctrl;
    localparam int W = 16;
    localparam logic [30:0] P = 31'h7fffffff;
    typedef logic [W-1:0][30:0] st_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m31_round_ctrl_if #(.WIDTH(W), .RW(5)) b0();
    m31_round_ctrl_if #(.WIDTH(W), .RW(5)) b1();
`ifdef M31_RC_ABORT_EN
    logic abort = 1'b0;
`endif

    m31_round_ctrl #(.WIDTH(W), .DP_LAT(1)) d0 (
        .clk(clk), .rst_n(rst_n),
`ifdef M31_RC_ABORT_EN
        .abort_i(abort),
`endif
        .bus(b0)
    );
    m31_round_ctrl #(.WIDTH(W), .DP_LAT(3)) d1 (
        .clk(clk), .rst_n(rst_n),
`ifdef M31_RC_ABORT_EN
        .abort_i(1'b0),
`endif
        .bus(b1)
    );

    function automatic st_t dp_f(input st_t s, input logic [4:0] r);
        st_t o;
        logic [31:0] t;
        for (int j = 0; j < W; j++) begin
            t = {1'b0, s[j]} + 32'd1 + (j == 0 ? {27'd0, r} : 32'd0);
            o[j] = t >= {1'b0, P} ? 31'(t - {1'b0, P}) : t[30:0];
        end
        return o;
    endfunction

    function automatic st_t model(input st_t s);
        st_t x = s;
        for (int p = 0; p < 23; p++) x = dp_f(x, 5'(p));
        return x;
    endfunction

    function automatic logic [1:0] kexp(input int p);
        return p == 0 ? 2'b00 : p <= 4 ? 2'b01 : p <= 18 ? 2'b10 : 2'b01;
    endfunction

    // stub datapaths: result valid exactly DP_LAT cycles after issue, zero otherwise
    st_t s1a, s1b;
    always_ff @(posedge clk) begin
        b0.dp_state_i <= b0.dp_valid_o ? dp_f(b0.dp_state_o, b0.dp_round_o) : '0;
        s1a <= b1.dp_valid_o ? dp_f(b1.dp_state_o, b1.dp_round_o) : '0;
        s1b <= s1a;
        b1.dp_state_i <= s1b;
    end

    int ntot = 0;
    int npass = 0;
    st_t exp_q[$];

    task automatic chk(input string tag, input logic [495:0] obs, input logic [495:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run0(input string tag, input st_t s);
        int n;
        @(negedge clk);
        b0.in_state = s;
        b0.in_valid = 1'b1;
        exp_q.push_back(model(s));
        @(negedge clk);
        b0.in_valid = 1'b0;
        n = 0;
        while (!b0.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, b0.out_valid, 1'b1);
        chk({tag, "_state"}, b0.out_state, exp_q.size() > 0 ? exp_q.pop_front() : '0);
    endtask

    initial begin
        st_t a, c, got;
        int n, iss, prev;
        logic ok;
        b0.in_valid = 1'b0; b0.in_state = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_state = '0; b1.out_ready = 1'b1;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", b0.in_ready, 1'b1);
        chk("rst_out_valid", b0.out_valid, 1'b0);
        chk("rst_busy", b0.busy_o, 1'b0);
        chk("rst_dp_valid", b0.dp_valid_o, 1'b0);
        chk("rst_dp_state", b0.dp_state_o, '0);
        chk("rst_in_ready_d1", b1.in_ready, 1'b1);
        rst_n = 1'b1;

        // single permutation, lanes = index, out_ready held low for backpressure
        for (int j = 0; j < W; j++) a[j] = 31'(j);
        @(negedge clk);
        b0.in_state = a;
        b0.in_valid = 1'b1;
        exp_q.push_back(model(a));
        chk("accept_ready", b0.in_ready, 1'b1);
        @(negedge clk);
        b0.in_valid = 1'b0;
        n = 1; iss = 0; ok = 1'b1;
        while (!b0.out_valid && n < 200) begin
            if (b0.dp_valid_o) begin
                ok &= b0.dp_kind_o == kexp(iss) && b0.dp_round_o == 5'(iss) && n == 1 + iss * 2;
                iss++;
            end
            @(negedge clk);
            n++;
        end
        chk("kind_schedule", ok, 1'b1);
        chk("issue_count", iss, 23);
        chk("out_cycle", n, 47);
        got = b0.out_state;
        chk("lane0", got[0], 31'd276);
        chk("lane1", got[1], 31'd24);
        chk("lane15", got[15], 31'd38);

        // backpressure: result held, new input ignored
        b0.in_valid = 1'b1;
        b0.in_state = ~a;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ok &= b0.out_valid && !b0.in_ready && b0.busy_o && b0.out_state == got;
        end
        chk("backpressure_hold", ok, 1'b1);
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        chk("sb_first", b0.out_state, exp_q.pop_front());
        @(negedge clk);
        chk("idle_in_ready", b0.in_ready, 1'b1);
        chk("idle_out_valid", b0.out_valid, 1'b0);
        chk("idle_busy", b0.busy_o, 1'b0);

        // DP_LAT=3 with lanes at p-1: wraps mod p
        for (int j = 0; j < W; j++) c[j] = P - 31'd1;
        @(negedge clk);
        b1.in_state = c;
        b1.in_valid = 1'b1;
        @(negedge clk);
        b1.in_valid = 1'b0;
        n = 1; iss = 0; prev = 0; ok = 1'b1;
        while (!b1.out_valid && n < 300) begin
            if (b1.dp_valid_o) begin
                ok &= iss == 0 ? n == 1 : n - prev == 4;
                prev = n;
                iss++;
            end
            @(negedge clk);
            n++;
        end
        chk("lat3_spacing", ok, 1'b1);
        chk("lat3_issues", iss, 23);
        chk("lat3_out_cycle", n, 93);
        chk("lat3_lane1", b1.out_state[1], 31'd22);
        chk("lat3_state", b1.out_state, model(c));
        @(negedge clk);
        chk("lat3_consumed", b1.out_valid, 1'b0);

        // back-to-back with in_valid held high
        for (int j = 0; j < W; j++) a[j] = 31'($urandom_range(0, 32'h7ffffffe));
        for (int j = 0; j < W; j++) c[j] = 31'($urandom_range(0, 32'h7ffffffe));
        @(negedge clk);
        b0.in_state = a;
        b0.in_valid = 1'b1;
        exp_q.push_back(model(a));
        chk("b2b_ready", b0.in_ready, 1'b1);
        @(negedge clk);
        b0.in_state = c;
        exp_q.push_back(model(c));
        n = 0;
        while (!b0.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first", b0.out_state, exp_q.pop_front());
        @(negedge clk);
        chk("b2b_accept_next", b0.in_ready, 1'b1);
        @(negedge clk);
        b0.in_valid = 1'b0;
        chk("b2b_busy", b0.busy_o, 1'b1);
        n = 0;
        while (!b0.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second", b0.out_state, exp_q.size() > 0 ? exp_q.pop_front() : '0);
        chk("sb_empty", exp_q.size(), 0);

        // reset at pass 10
        @(negedge clk);
        b0.in_state = ~a;
        b0.in_valid = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        n = 0;
        while (!(b0.dp_valid_o && b0.dp_round_o == 5'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pass10", b0.dp_round_o, 5'd10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", b0.busy_o, 1'b0);
        chk("mid_rst_in_ready", b0.in_ready, 1'b1);
        chk("mid_rst_dp_state", b0.dp_state_o, '0);
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            ok &= !b0.out_valid;
        end
        chk("mid_rst_no_out", ok, 1'b1);
        run0("after_rst", c);

`ifdef M31_RC_ABORT_EN
        // abort in idle is harmless
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_ready", b0.in_ready, 1'b1);
        // abort at pass 10
        b0.in_state = a;
        b0.in_valid = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        n = 0;
        while (!(b0.dp_valid_o && b0.dp_round_o == 5'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pass10", b0.dp_round_o, 5'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", b0.busy_o, 1'b0);
        chk("abort_in_ready", b0.in_ready, 1'b1);
        chk("abort_dp_state", b0.dp_state_o, '0);
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            ok &= !b0.out_valid;
        end
        chk("abort_no_out", ok, 1'b1);
        run0("after_abort", a);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
